seven_segment_capture: RTL

Monitor/reader for the multiplexed, active-low seven-segment display bus: anode enables plus the shared 7-bit segment pattern. It reconstructs the 4-bit digit value shown on each digit position. Used on the board self-test path and in benches to check what the display drivers emit. Patterns are accepted only after they hold stable for a dwell time. Each completed scan of all positions is reported as a frame.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_pattern_decode.sv | 33 +++
 rtl/seven_segment_capture.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg: shared active-low {a,b,c,d,e,f,g} patterns and codes. r1.0 |
// +----------------------------------------------------------------------+
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CODE_INVALID = 4'hE;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pattern_decode: segment pattern -> 4-bit code lookup. r1.0      |
// +----------------------------------------------------------------------+
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o,
    output logic       invalid_o
);

    always_comb begin
        code_o    = CODE_INVALID;
        invalid_o = 1'b1;
        case (pattern_i)
            SEG_0:     begin code_o = 4'd0;       invalid_o = 1'b0; end
            SEG_1:     begin code_o = 4'd1;       invalid_o = 1'b0; end
            SEG_2:     begin code_o = 4'd2;       invalid_o = 1'b0; end
            SEG_3:     begin code_o = 4'd3;       invalid_o = 1'b0; end
            SEG_4:     begin code_o = 4'd4;       invalid_o = 1'b0; end
            SEG_5:     begin code_o = 4'd5;       invalid_o = 1'b0; end
            SEG_6:     begin code_o = 4'd6;       invalid_o = 1'b0; end
            SEG_7:     begin code_o = 4'd7;       invalid_o = 1'b0; end
            SEG_8:     begin code_o = 4'd8;       invalid_o = 1'b0; end
            SEG_9:     begin code_o = 4'd9;       invalid_o = 1'b0; end
            SEG_BLANK: begin code_o = CODE_BLANK; invalid_o = 1'b0; end
            default:   begin code_o = CODE_INVALID; invalid_o = 1'b1; end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_segment_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_segment_capture: dwell-filtered reader of a muxed 7-seg bus.   |
// | Revision: r1.0                                                       |
// +----------------------------------------------------------------------+
module seven_segment_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              disp,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [4*NUM_DIGITS-1:0] frame_digits,
    output logic                    frame_valid,
    output logic                    pattern_err,
    output logic                    conflict_err,
    output logic                    stale
);

    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_CNT_DONE = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] C_CNT_PRE  = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] C_IDLE_MAX = TW'(TIMEOUT_CYCLES);

    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              disp_q, prev_disp_q;
    logic [SW-1:0]           prev_slot_q;
    logic                    prev_single_q, prev_conflict_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           idle_q, idle_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d, valid_q, valid_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d, frame_digits_q, frame_digits_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    pattern_err_q, pattern_err_d;
    logic                    conflict_err_q, stale_q, stale_d;

    logic          any_low, multi_low, single, conflict, same_pair, commit;
    logic [SW-1:0] slot;
    logic [3:0]    code;
    logic          code_invalid;

    always_comb begin
        any_low   = 1'b0;
        multi_low = 1'b0;
        slot      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) begin
                multi_low = multi_low | any_low;
                any_low   = 1'b1;
                slot      = SW'(i);
            end
        end
    end

    assign single    = any_low & ~multi_low;
    assign conflict  = multi_low;
    assign same_pair = prev_single_q && (slot == prev_slot_q) && (disp_q == prev_disp_q);
    // Commit fires only on the S-1 -> S step, so a saturated counter never re-commits.
    assign commit    = single && same_pair && (cnt_q == C_CNT_PRE);

    always_comb begin
        cnt_d = '0;
        if (single) begin
            if (!same_pair)              cnt_d = CW'(1);
            else if (cnt_q == C_CNT_DONE) cnt_d = cnt_q;
            else                          cnt_d = cnt_q + 1'b1;
        end
    end

    seg7_pattern_decode u_decode (
        .pattern_i (disp_q),
        .code_o    (code),
        .invalid_o (code_invalid)
    );

    always_comb begin
        digits_d       = digits_q;
        valid_d        = valid_q;
        seen_d         = seen_q;
        frame_digits_d = frame_digits_q;
        frame_valid_d  = 1'b0;
        pattern_err_d  = 1'b0;
        stale_d        = 1'b0;
        idle_d         = idle_q;
        if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (slot == SW'(i)) begin
                    digits_d[4*i +: 4] = code;
                    valid_d[i]         = 1'b1;
                    seen_d[i]          = 1'b1;
                end
            end
            pattern_err_d = code_invalid;
            idle_d        = '0;
            if (&seen_d) begin
                frame_digits_d = digits_d;
                frame_valid_d  = 1'b1;
                seen_d         = '0;
            end
        end else if (idle_q != C_IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
            if (idle_d == C_IDLE_MAX) begin
                stale_d = 1'b1;
                valid_d = '0;
                seen_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q            <= '1;
            disp_q          <= SEG_BLANK;
            prev_disp_q     <= SEG_BLANK;
            prev_slot_q     <= '0;
            prev_single_q   <= 1'b0;
            prev_conflict_q <= 1'b0;
            cnt_q           <= '0;
            idle_q          <= '0;
            seen_q          <= '0;
            valid_q         <= '0;
            digits_q        <= '0;
            frame_digits_q  <= '0;
            frame_valid_q   <= 1'b0;
            pattern_err_q   <= 1'b0;
            conflict_err_q  <= 1'b0;
            stale_q         <= 1'b0;
        end else begin
            an_q            <= an;
            disp_q          <= disp;
            prev_disp_q     <= disp_q;
            prev_slot_q     <= slot;
            prev_single_q   <= single;
            prev_conflict_q <= conflict;
            cnt_q           <= cnt_d;
            idle_q          <= idle_d;
            seen_q          <= seen_d;
            valid_q         <= valid_d;
            digits_q        <= digits_d;
            frame_digits_q  <= frame_digits_d;
            frame_valid_q   <= frame_valid_d;
            pattern_err_q   <= pattern_err_d;
            conflict_err_q  <= conflict & ~prev_conflict_q;
            stale_q         <= stale_d;
        end
    end

    assign digits       = digits_q;
    assign digit_valid  = valid_q;
    assign frame_digits = frame_digits_q;
    assign frame_valid  = frame_valid_q;
    assign pattern_err  = pattern_err_q;
    assign conflict_err = conflict_err_q;
    assign stale        = stale_q;

endmodule
`default_nettype wire
